// File: rtl/pipeline_control_sequencer.sv
// Pipeline-register control sequencer: load-use bubbles, multi-cycle branch flush,
// memory freeze and halt, with saturating stall/flush event counters.
module pipeline_control_sequencer #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic             mem_busy,
  input  logic             halt,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic [1:0]       fsm_state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    FLUSH      = 2'b10,
    HALTED     = 2'b11
  } state_t;

  // Remaining FLUSH cycles after the current one; a branch resolves in RUN, so
  // only FLUSH_CYCLES-1 cycles remain, i.e. the counter starts at FLUSH_CYCLES-2.
  localparam logic   [3:0] RELOAD    = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;
  localparam state_t       BRANCH_NS = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

  state_t     state, next_state;
  logic [3:0] cnt, next_cnt;
  logic       stall_inc, flush_inc;

  assign fsm_state = state;

  always_comb begin
    next_state   = state;
    next_cnt     = cnt;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      ex_mem_write = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (state == HALTED) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else if (mem_busy) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      ex_mem_write = 1'b0;
      stall_inc    = 1'b1;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      flush_inc   = 1'b1;
      next_state  = BRANCH_NS;
      next_cnt    = RELOAD;
    end else if (state == FLUSH) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      if (cnt == 4'd0) next_state = RUN;
      else             next_cnt   = cnt - 4'd1;
    end else if (halt) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      ex_mem_write = 1'b0;
      next_state   = HALTED;
    end else if (!stall && state == RUN) begin
      // Bubble: hold PC and IF/ID, let the load in EX advance.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      stall_inc   = 1'b1;
      next_state  = LOAD_STALL;
    end else begin
      next_state = RUN;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RUN;
      cnt         <= 4'd0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      if (stall_inc && stall_count != {CNT_W{1'b1}}) stall_count <= stall_count + 1'b1;
      if (flush_inc && flush_count != {CNT_W{1'b1}}) flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_control_sequencer.sv
// Directed bench: two sequencer instances (FLUSH_CYCLES=2 / 16-bit counters and
// FLUSH_CYCLES=3 / 2-bit counters) share stimulus; expectations are hand-computed.
module tb_pipeline_control_sequencer;

  logic clock = 1'b0;
  logic reset, stall, branch_taken, mem_busy, halt;

  logic       pc2, ifw2, iff2, idf2, exw2;
  logic [1:0] st2;
  logic [15:0] sc2, fc2;
  logic       pc3, ifw3, iff3, idf3, exw3;
  logic [1:0] st3;
  logic [1:0] sc3, fc3;

  int compared   = 0;
  int mismatched = 0;

  // Output vectors packed as {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write}
  localparam logic [4:0] NORM = 5'b11001;
  localparam logic [4:0] FRZ  = 5'b00000;
  localparam logic [4:0] FLS  = 5'b11111;
  localparam logic [4:0] BUB  = 5'b00011;
  localparam logic [4:0] RST  = 5'b00110;

  logic [4:0] o2, o3;
  assign o2 = {pc2, ifw2, iff2, idf2, exw2};
  assign o3 = {pc3, ifw3, iff3, idf3, exw3};

  always #5 clock = ~clock;

  pipeline_control_sequencer #(.FLUSH_CYCLES(2), .CNT_W(16)) dut2 (
    .clock(clock), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .halt(halt), .pc_write(pc2), .if_id_write(ifw2),
    .if_id_flush(iff2), .id_ex_flush(idf2), .ex_mem_write(exw2),
    .fsm_state(st2), .stall_count(sc2), .flush_count(fc2)
  );

  pipeline_control_sequencer #(.FLUSH_CYCLES(3), .CNT_W(2)) dut3 (
    .clock(clock), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .halt(halt), .pc_write(pc3), .if_id_write(ifw3),
    .if_id_flush(iff3), .id_ex_flush(idf3), .ex_mem_write(exw3),
    .fsm_state(st3), .stall_count(sc3), .flush_count(fc3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle the combinational outputs before sampling.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    stall = 1'b1; branch_taken = 1'b0; mem_busy = 1'b0; halt = 1'b0;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b1; branch_taken = 1'b1;
    @(negedge clock);
    check("rst_out0", 32'(o2), 32'(RST));
    tick();
    check("rst_out1", 32'(o2), 32'(RST));
    check("rst_state", 32'(st2), 32'd0);
    tick();
    reset = 1'b0; branch_taken = 1'b0; settle();
    check("rel_out", 32'(o2), 32'(NORM));
    check("rel_state", 32'(st2), 32'd0);
    check("rel_sc", 32'(sc2), 32'd0);
    check("rel_fc", 32'(fc2), 32'd0);

    // Load-use: stall low for two cycles, only the first one bubbles
    stall = 1'b0; settle();
    check("lu0_out", 32'(o2), 32'(BUB));
    tick();
    check("lu1_state", 32'(st2), 32'd1);
    check("lu1_out", 32'(o2), 32'(NORM));
    check("lu1_sc", 32'(sc2), 32'd1);
    tick();
    stall = 1'b1; settle();
    check("lu2_state", 32'(st2), 32'd0);
    check("lu2_out", 32'(o2), 32'(NORM));

    // Branch with FLUSH_CYCLES = 2
    branch_taken = 1'b1; settle();
    check("br0_out", 32'(o2), 32'(FLS));
    tick();
    branch_taken = 1'b0; settle();
    check("br1_state", 32'(st2), 32'd2);
    check("br1_out", 32'(o2), 32'(FLS));
    tick();
    check("br2_state", 32'(st2), 32'd0);
    check("br2_out", 32'(o2), 32'(NORM));
    check("br2_fc", 32'(fc2), 32'd1);

    reset = 1'b1; tick(); reset = 1'b0; settle();

    // Branch during FLUSH, FLUSH_CYCLES = 3: 3 + 2 flushed cycles
    branch_taken = 1'b1; settle();
    check("bf_a", 32'(o3), 32'(FLS));
    tick(); branch_taken = 1'b0; settle();
    check("bf_b", 32'(o3), 32'(FLS));
    check("bf_b_state", 32'(st3), 32'd2);
    tick(); branch_taken = 1'b1; settle();
    check("bf_c", 32'(o3), 32'(FLS));
    check("bf_c_state", 32'(st3), 32'd2);
    tick(); branch_taken = 1'b0; settle();
    check("bf_d", 32'(o3), 32'(FLS));
    tick();
    check("bf_e", 32'(o3), 32'(FLS));
    check("bf_e_state", 32'(st3), 32'd2);
    tick();
    check("bf_f", 32'(o3), 32'(NORM));
    check("bf_f_state", 32'(st3), 32'd0);
    check("bf_fc", 32'(fc3), 32'd2);

    // Freeze for 3 cycles in the middle of a FLUSH window
    branch_taken = 1'b1; settle();
    tick(); branch_taken = 1'b0; mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("fz_out", 32'(o3), 32'(FRZ));
      check("fz_state", 32'(st3), 32'd2);
      tick();
    end
    mem_busy = 1'b0; settle();
    check("fz_sc", 32'(sc3), 32'd3);
    check("fz_r0", 32'(o3), 32'(FLS));
    tick();
    check("fz_r1", 32'(o3), 32'(FLS));
    check("fz_r1_state", 32'(st3), 32'd2);
    tick();
    check("fz_r2", 32'(o3), 32'(NORM));
    check("fz_r2_state", 32'(st3), 32'd0);

    // Halt wins over stall; HALTED absorbs mem_busy and branch activity
    halt = 1'b1; stall = 1'b0; settle();
    check("h0_out", 32'(o2), 32'(FRZ));
    tick();
    idle();
    for (int i = 0; i < 10; i++) begin
      mem_busy = i[0]; branch_taken = i[1]; settle();
      check("h_out", 32'(o2), 32'(FRZ));
      check("h_state", 32'(st2), 32'd3);
      tick();
    end
    check("h_sc", 32'(sc2), 32'd3);
    check("h_fc", 32'(fc2), 32'd3);
    idle();
    reset = 1'b1; settle();
    check("hr_out", 32'(o2), 32'(RST));
    tick(); reset = 1'b0; settle();
    check("hr_state", 32'(st2), 32'd0);
    check("hr_out2", 32'(o2), 32'(NORM));

    // Saturation: 5 frozen cycles on a 2-bit counter stops at 3
    mem_busy = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    mem_busy = 1'b0; settle();
    check("sat_sc3", 32'(sc3), 32'd3);
    check("sat_sc2", 32'(sc2), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipeline_control_sequencer.md
# pipeline_control_sequencer

Sequences the pipeline-register control of the 4-bit-opcode processor. Consumes the hazard detection unit's load-use stall and branch-taken indications plus the data-memory busy and halt signals. Drives the PC write enable, the IF/ID write and flush, the ID/EX flush and the EX/MEM write enable. A small FSM enforces bubble insertion, a multi-cycle branch flush and global freeze, and exports saturating stall and flush event counters for performance debug.

## Interface

- FLUSH_CYCLES, default 2: consecutive cycles IF/ID and ID/EX are flushed per taken branch. Legal range 1–15.
- CNT_W, default 16: width of the performance counters.

- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  load-use request from hazard detection unit, active-low (0 = insert bubble)
- branch_taken  in  1  active-high; redirect resolved this cycle
- mem_busy  in  1  data memory not ready; freeze whole pipeline
- halt  in  1  halt instruction in EX
- pc_write  out  1  PC load enable
- if_id_write  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID clear to NOP
- id_ex_flush  out  1  ID/EX clear to NOP (bubble)
- ex_mem_write  out  1  EX/MEM enable (MEM/WB always advances)
- fsm_state  out  2  00 RUN, 01 LOAD_STALL, 10 FLUSH, 11 HALTED
- stall_count  out  CNT_W  cycles lost to load stall or freeze
- flush_count  out  CNT_W  taken branches accepted

## Operation

- Outputs are combinational from the current state, the flush counter and the current inputs (Mealy). State, flush counter and perf counters are registered.
- "Normal" output set: pc_write = if_id_write = ex_mem_write = 1, flushes = 0.
- "Freeze" output set: all writes 0, flushes 0.
- Priority in RUN and LOAD_STALL is mem_busy > branch_taken > halt > stall.
- **mem_busy = 1 (any state except HALTED):**
  - Output set is freeze.
  - State and flush counter hold.
  - stall_count increments.
  - All other inputs are ignored.
- **RUN:**
  - branch_taken: pc_write = 1, if_id_write = 1, if_id_flush = 1, id_ex_flush = 1, flush_count increments. If FLUSH_CYCLES > 1, go to FLUSH with counter = FLUSH_CYCLES − 2; otherwise stay in RUN.
  - halt: freeze output set, go to HALTED.
  - stall = 0: pc_write = 0, if_id_write = 0, id_ex_flush = 1, ex_mem_write = 1, stall_count increments, go to LOAD_STALL.
  - Otherwise: normal output set.
- **LOAD_STALL:**
  - Lasts exactly one cycle and always returns to RUN.
  - stall is ignored in this state: no back-to-back bubble for the same hazard.
  - branch_taken and mem_busy are handled as in RUN. A branch here goes to FLUSH or RUN per FLUSH_CYCLES.
  - Otherwise the output set is normal.
- **FLUSH:**
  - pc_write = 1, if_id_write = 1, if_id_flush = 1, id_ex_flush = 1.
  - stall and halt are ignored.
  - If counter = 0, go to RUN; else decrement.
  - A new branch_taken here reloads counter = FLUSH_CYCLES − 2 (or goes to RUN if FLUSH_CYCLES = 1) and increments flush_count.
- **HALTED:**
  - Freeze output set.
  - Absorbing state; only reset exits. mem_busy has no effect.
- **Counters:**
  - Both counters saturate at 2^CNT_W − 1 and never wrap.
  - stall_count counts one per freeze or load-bubble cycle; a cycle that is both counts once.

## Timing

- Hazard response is zero-latency: outputs react in the same cycle the input is asserted.
- The state change is visible from the next rising edge.
- Load-use costs exactly 1 lost cycle.
- A taken branch costs FLUSH_CYCLES flushed cycles: the resolving cycle plus FLUSH_CYCLES − 1 cycles in FLUSH.
- mem_busy adds exactly one frozen cycle per asserted cycle.
- **Reset:**
  - While reset = 1: pc_write = if_id_write = ex_mem_write = 0, if_id_flush = id_ex_flush = 1.
  - On the edge with reset = 1: state ← RUN, flush counter ← 0, stall_count ← 0, flush_count ← 0.
  - Reset wins over every other input and is valid mid-FLUSH or in HALTED.
  - First normal output is in the cycle after reset deasserts.

## Test plan

- **Reset:** reset = 1 for 2 cycles with branch_taken = 1 → flushes = 1, writes = 0, fsm_state = 00, both counts 0 after release.
- **Load-use:** stall = 0 held for 2 cycles in RUN → cycle 0: pc_write = 0, id_ex_flush = 1, fsm_state → 01. Cycle 1: normal outputs, back to 00. stall_count = 1.
- **Branch, FLUSH_CYCLES = 2:** branch_taken pulse → 2 consecutive cycles with if_id_flush = id_ex_flush = 1, then RUN. flush_count = 1.
- **Branch during FLUSH, FLUSH_CYCLES = 3:** second branch_taken in FLUSH → flush window restarts, 3 + 2 total flushed cycles. flush_count = 2.
- **Freeze mid-FLUSH:** mem_busy = 1 for 3 cycles in FLUSH → all outputs 0, counter holds, stall_count += 3, flush resumes afterwards.
- **Halt:** halt = 1 with stall = 0 → HALTED (11), freeze persists 10 cycles despite mem_busy/branch toggling. Synchronous reset returns to RUN.
